// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: run/set-time sequencer for the HH:MM:SS clock datapath.
// Ports:
//   clk, rst (async, active-low)    - clock and reset
//   btn_mode, btn_inc               - raw active-high push-buttons (async to clk)
//   sec_en                          - 1 Hz count enable to the seconds counter (RUN only)
//   sec_clr, min_adj, hour_adj      - single-cycle clear/increment pulses
//   mode                            - 00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
//   blink                           - blank strobe for the field being edited
module clock_mode_ctrl #(
    parameter int CLK_DIV       = 50_000_000,
    parameter int REP_DLY       = 25_000_000,
    parameter int REP_PER       = 10_000_000,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       sec_en,
    output logic       sec_clr,
    output logic       min_adj,
    output logic       hour_adj,
    output logic [1:0] mode,
    output logic       blink
);
    localparam int PW   = $clog2(CLK_DIV);
    localparam int HMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
    logic [TW-1:0] to_q, to_d;
    logic [1:0]    msync_q, isync_q;
    logic          mprev_q, iprev_q;
    logic          sec_en_q, sec_en_d;
    logic          sec_clr_q, sec_clr_d;
    logic          min_q, min_d;
    logic          hour_q, hour_d;
    logic          blink_q, blink_d;
    logic          mode_ev, inc_ev, inc_held, tick, adj;

    assign inc_held = isync_q[1];
    assign mode_ev  = msync_q[1] & ~mprev_q;
    assign inc_ev   = inc_held & ~iprev_q;
    assign tick     = pre_q == PW'(CLK_DIV - 1);

    always_comb begin
        state_d   = state_q;
        pre_d     = tick ? '0 : pre_q + 1'b1;
        to_d      = to_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        adj       = 1'b0;
        sec_en_d  = 1'b0;
        sec_clr_d = 1'b0;
        min_d     = 1'b0;
        hour_d    = 1'b0;
        if (mode_ev) begin
            // MODE wins over a coincident INC; repeat state never survives a transition
            state_d = state_t'(state_q + 2'd1);
            to_d    = '0;
            hold_d  = '0;
            rep_d   = 1'b0;
            if (state_q == SET_SEC) pre_d = '0;
        end else if (state_q == RUN) begin
            sec_en_d = tick;
        end else if (!inc_held && tick && to_q == TW'(TIMEOUT_TICKS - 1)) begin
            state_d = RUN;
            pre_d   = '0;
            to_d    = '0;
            hold_d  = '0;
            rep_d   = 1'b0;
        end else begin
            // a held INC counts as activity, so long auto-repeat runs never time out
            to_d = inc_held ? '0 : to_q + TW'(tick);
            if (state_q == SET_SEC) begin
                sec_clr_d = inc_ev;
            end else begin
                // hold_q counts cycles since the last pulse; rep_q selects the first-delay or repeat period
                adj    = inc_ev || (inc_held && hold_q != '0 &&
                         hold_q == (rep_q ? HW'(REP_PER) : HW'(REP_DLY)));
                hold_d = !inc_held ? '0 : (adj ? HW'(1) : (hold_q == '0 ? '0 : hold_q + 1'b1));
                rep_d  = inc_held && !inc_ev && (rep_q || adj);
                hour_d = adj && state_q == SET_HOUR;
                min_d  = adj && state_q == SET_MIN;
            end
        end
        blink_d = state_d != RUN && pre_d < PW'(CLK_DIV / 2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            pre_q     <= '0;
            hold_q    <= '0;
            rep_q     <= 1'b0;
            to_q      <= '0;
            msync_q   <= '0;
            isync_q   <= '0;
            mprev_q   <= 1'b0;
            iprev_q   <= 1'b0;
            sec_en_q  <= 1'b0;
            sec_clr_q <= 1'b0;
            min_q     <= 1'b0;
            hour_q    <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            to_q      <= to_d;
            msync_q   <= {msync_q[0], btn_mode};
            isync_q   <= {isync_q[0], btn_inc};
            mprev_q   <= msync_q[1];
            iprev_q   <= isync_q[1];
            sec_en_q  <= sec_en_d;
            sec_clr_q <= sec_clr_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            blink_q   <= blink_d;
        end
    end

    assign sec_en   = sec_en_q;
    assign sec_clr  = sec_clr_q;
    assign min_adj  = min_q;
    assign hour_adj = hour_q;
    assign mode     = state_q;
    assign blink    = blink_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: directed and randomized checks of clock_mode_ctrl against a cycle-indexed behavioural model.
module tb_clock_mode_ctrl;
    localparam int CD = 10, RD = 20, RP = 5, TT = 3;

    logic       clk = 0, rst = 1, btn_mode = 0, btn_inc = 0;
    logic       sec_en, sec_clr, min_adj, hour_adj, blink;
    logic [1:0] mode;

    clock_mode_ctrl #(.CLK_DIV(CD), .REP_DLY(RD), .REP_PER(RP), .TIMEOUT_TICKS(TT)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_en(sec_en), .sec_clr(sec_clr), .min_adj(min_adj), .hour_adj(hour_adj),
        .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    int nv = 0, nmis = 0;
    int m_mode, m_pre, m_idle, m_age, k;
    logic qm[$], qi[$];
    logic [6:0] exp_v;
    int n_sec, first_sec, n_hour, hour_k, n_clr, n_blink, entry_k, exit_k, sec_after;
    int min_q[$];
    logic [1:0] last_mode = 0;

    function automatic logic smp(input bit which, input int j);
        if (j < 1) return 1'b0;
        return which ? qi[j-1] : qm[j-1];
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        nv++;
        assert (obs === expv) else begin
            nmis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pre = 0; m_idle = 0; m_age = -1; k = 0;
        qm.delete(); qi.delete();
        exp_v = '0;
    endtask

    // Model works from the sampled button history: an event is a 0->1 in the sample
    // stream seen two edges late, and repeats follow from the pulse age directly.
    task automatic model_step(input logic bm, input logic bi);
        logic mev, iev, held, tck, e_sec, e_clr, e_min, e_hour, pulse, e_blink;
        int old;
        k++;
        qm.push_back(bm);
        qi.push_back(bi);
        mev  = smp(0, k-2) && !smp(0, k-3);
        iev  = smp(1, k-2) && !smp(1, k-3);
        held = smp(1, k-2);
        tck  = m_pre == CD - 1;
        {e_sec, e_clr, e_min, e_hour} = '0;
        old = m_mode;
        m_pre = (m_pre + 1) % CD;
        if (mev) begin
            m_mode = (m_mode + 1) % 4;
            m_idle = 0;
            m_age = -1;
            if (old == 3) m_pre = 0;
        end else if (m_mode == 0) begin
            e_sec = tck;
        end else begin
            if (held) m_idle = 0;
            else if (tck) m_idle++;
            if (m_idle == TT) begin
                m_mode = 0; m_pre = 0; m_idle = 0; m_age = -1;
            end else if (m_mode == 3) begin
                e_clr = iev;
            end else begin
                pulse = 0;
                if (!held) m_age = -1;
                else if (iev) begin m_age = 0; pulse = 1; end
                else if (m_age >= 0) begin
                    m_age++;
                    pulse = m_age == RD || (m_age > RD && (m_age - RD) % RP == 0);
                end
                e_hour = pulse && m_mode == 1;
                e_min  = pulse && m_mode == 2;
            end
        end
        e_blink = m_mode != 0 && m_pre < CD / 2;
        exp_v = {e_sec, e_clr, e_min, e_hour, 2'(m_mode), e_blink};
    endtask

    task automatic step(input logic bm, input logic bi);
        logic [6:0] obs;
        btn_mode = bm;
        btn_inc  = bi;
        @(posedge clk);
        if (!rst) model_reset(); else model_step(bm, bi);
        @(negedge clk);
        obs = {sec_en, sec_clr, min_adj, hour_adj, mode, blink};
        nv++;
        assert (obs === exp_v) else begin
            nmis++;
            $error("FAIL cycle k=%0d {sec_en,sec_clr,min,hour,mode,blink}: observed %b expected %b", k, obs, exp_v);
        end
        if (sec_en) begin
            n_sec++;
            if (first_sec < 0) first_sec = k;
            if (exit_k >= 0 && sec_after < 0) sec_after = k;
        end
        if (hour_adj) begin n_hour++; hour_k = k; end
        if (min_adj) min_q.push_back(k);
        if (sec_clr) n_clr++;
        if (blink) n_blink++;
        if (mode == 2'd0 && last_mode != 2'd0) exit_k = k;
        if (mode == 2'd1 && last_mode == 2'd0) entry_k = k;
        last_mode = mode;
    endtask

    task automatic run(input int n, input logic bm, input logic bi);
        repeat (n) step(bm, bi);
    endtask

    task automatic press_mode();
        run(2, 1, 0);
        run(2, 0, 0);
    endtask

    task automatic clr();
        n_sec = 0; first_sec = -1; n_hour = 0; hour_k = -1; n_clr = 0; n_blink = 0;
        entry_k = -1; exit_k = -1; sec_after = -1;
        min_q.delete();
    endtask

    task automatic do_reset(input string tag);
        rst = 0;
        #1;
        chk(tag, int'({sec_en, sec_clr, min_adj, hour_adj, mode, blink}), 0);
        model_reset();
        run(2, 0, 0);
        rst = 1;
        model_reset();
        last_mode = 0;
    endtask

    initial begin
        int t0, ei, e_entry;
        int off[5] = '{0, 20, 25, 30, 35};
        logic rm, ri;
        @(negedge clk);
        do_reset("reset_initial");

        // 1: free-running RUN
        clr();
        run(100, 0, 0);
        chk("t1_first_sec_en", first_sec, 10);
        chk("t1_sec_en_count", n_sec, 10);
        chk("t1_blink_count", n_blink, 0);
        chk("t1_mode", int'(mode), 0);

        // 2: SET_HOUR, single INC
        clr();
        press_mode();
        run(3, 0, 0);
        ei = k + 1;
        run(2, 0, 1);
        run(6, 0, 0);
        chk("t2_mode", int'(mode), 1);
        chk("t2_hour_count", n_hour, 1);
        chk("t2_hour_latency", hour_k, ei + 2);
        chk("t2_sec_en_in_set", n_sec, 0);

        // 3: SET_MIN auto-repeat
        clr();
        press_mode();
        t0 = k + 3;
        run(40, 0, 1);
        run(10, 0, 0);
        chk("t3_mode", int'(mode), 2);
        chk("t3_min_count", min_q.size(), 5);
        for (int i = 0; i < 5 && i < min_q.size(); i++) chk("t3_min_offset", min_q[i] - t0, off[i]);
        chk("t3_hour_count", n_hour, 0);

        // 4: SET_SEC clear and exit
        do_reset("reset_t4");
        clr();
        press_mode();
        press_mode();
        press_mode();
        chk("t4_mode_set_sec", int'(mode), 3);
        run(2, 0, 1);
        run(2, 0, 0);
        chk("t4_sec_clr_count", n_clr, 1);
        press_mode();
        run(20, 0, 0);
        chk("t4_mode_run", int'(mode), 0);
        chk("t4_sec_en_after_exit", sec_after - exit_k, 10);

        // 5: timeout, then timeout extended by INC
        clr();
        press_mode();
        run(40, 0, 0);
        chk("t5_timeout_window", int'(exit_k - entry_k > 20 && exit_k - entry_k <= 30), 1);
        chk("t5_mode_run", int'(mode), 0);
        clr();
        press_mode();
        e_entry = entry_k;
        run(14, 0, 0);
        run(2, 0, 1);
        run(60, 0, 0);
        chk("t5_extended", int'(exit_k - e_entry > 30), 1);
        chk("t5_hour_count", n_hour, 1);

        // 6: simultaneous MODE+INC, then reset during hold
        do_reset("reset_t6");
        press_mode();
        run(2, 0, 0);
        clr();
        run(2, 1, 1);
        run(4, 0, 0);
        chk("t6_mode", int'(mode), 2);
        chk("t6_no_adj", n_hour + min_q.size(), 0);
        run(10, 0, 1);
        chk("t6_min_before_reset", min_q.size(), 1);
        do_reset("t6_reset_during_hold");
        chk("t6_mode_after_reset", int'(mode), 0);

        // randomized button activity with occasional resets
        rm = 0;
        ri = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) rm = ~rm;
            if ($urandom_range(0, 14) == 0) ri = ~ri;
            if ($urandom_range(0, 1499) == 0) do_reset("reset_random");
            step(rm, ri);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nv, nmis);
        $finish;
    end
endmodule
